// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Brings a PLL out of reset and qualifies its lock before releasing the
//   downstream reset. The PLL is held in reset for a fixed pulse, then the
//   block waits for a synchronized lock that must stay high for a set number
//   of cycles. Each bring-up attempt has a timeout. A timeout triggers a retry
//   until the retry budget is spent, and then the block parks in FAIL. Losing
//   lock while running restarts the sequence and sets a sticky flag.
//
// Ports
//   refclk      in   single clock domain
//   rst         in   synchronous, active-high reset
//   enable      in   level request for PLL bring-up (0 aborts to IDLE)
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   pll_rst     out  reset to the PLL (high in IDLE, RESET, FAIL)
//   sys_rst_out out  active-high reset for PLL-clocked logic (low only in RUN)
//   ready       out  PLL locked and stable (RUN)
//   fail        out  retries exhausted (FAIL)
//   lol_sticky  out  loss of lock seen in RUN; cleared only by rst
//   retry_cnt   out  current retry count, saturating at MAX_RETRIES
//   state       out  FSM state encoding
module pll_lock_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_out,
    output logic       ready,
    output logic       fail,
    output logic       lol_sticky,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET     = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    localparam int PW = $clog2(RST_PULSE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRIES);

    // The stable window must be able to finish before the timeout can fire.
    if (LOCK_TIMEOUT_CYC <= LOCK_STABLE_CYC + 2) begin : g_bad_timeout
        $error("LOCK_TIMEOUT_CYC must exceed LOCK_STABLE_CYC + 2");
    end
    if (MAX_RETRIES > 7 || MAX_RETRIES < 0) begin : g_bad_retries
        $error("MAX_RETRIES must fit the 3-bit retry_cnt");
    end

    // Retry counter never wraps: it holds at the configured maximum.
    function automatic logic [2:0] retry_sat_inc(input logic [2:0] r);
        return (r >= RETRY_MAX) ? r : r + 3'd1;
    endfunction

    logic          sync_p0;
    logic          locked_s;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [SW-1:0] stable_cnt;

    logic [2:0]    state_nxt;
    logic [PW-1:0] pulse_nxt;
    logic [TW-1:0] timeout_nxt;
    logic [SW-1:0] stable_nxt;
    logic [2:0]    retry_nxt;
    logic          lol_nxt;
    logic          timeout_hit;

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_cnt;
        timeout_nxt = timeout_cnt;
        stable_nxt  = stable_cnt;
        retry_nxt   = retry_cnt;
        lol_nxt     = lol_sticky;

        if (!enable) begin
            // Dropping enable aborts from anywhere; the sticky flag survives.
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt   = S_RESET;
                    pulse_nxt   = '0;
                    timeout_nxt = '0;
                    retry_nxt   = 3'd0;
                end
                S_RESET: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_nxt   = S_WAIT_LOCK;
                        timeout_nxt = '0;
                    end else begin
                        pulse_nxt = pulse_cnt + PW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (timeout_hit) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAIL;
                        end else begin
                            state_nxt = S_RESET;
                            pulse_nxt = '0;
                            retry_nxt = retry_sat_inc(retry_cnt);
                        end
                    end else begin
                        timeout_nxt = timeout_cnt + TW'(1);
                        if (locked_s) begin
                            state_nxt  = S_STABLE;
                            stable_nxt = '0;
                        end
                    end
                end
                S_STABLE: begin
                    // Completing the stable window wins over a same-cycle timeout.
                    if (locked_s && stable_cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                    end else if (timeout_hit) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAIL;
                        end else begin
                            state_nxt = S_RESET;
                            pulse_nxt = '0;
                            retry_nxt = retry_sat_inc(retry_cnt);
                        end
                    end else begin
                        // Timeout keeps running across lock chatter so a
                        // bouncing lock cannot hold the FSM here forever.
                        timeout_nxt = timeout_cnt + TW'(1);
                        if (!locked_s) begin
                            state_nxt = S_WAIT_LOCK;
                        end else begin
                            stable_nxt = stable_cnt + SW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_nxt = S_RESET;
                        pulse_nxt = '0;
                        lol_nxt   = 1'b1;
                        retry_nxt = 3'd0;
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and always match the visible state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_p0     <= 1'b0;
            locked_s    <= 1'b0;
            state       <= S_IDLE;
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            stable_cnt  <= '0;
            retry_cnt   <= 3'd0;
            lol_sticky  <= 1'b0;
            pll_rst     <= 1'b1;
            sys_rst_out <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            sync_p0     <= pll_locked;
            locked_s    <= sync_p0;
            state       <= state_nxt;
            pulse_cnt   <= pulse_nxt;
            timeout_cnt <= timeout_nxt;
            stable_cnt  <= stable_nxt;
            retry_cnt   <= retry_nxt;
            lol_sticky  <= lol_nxt;
            pll_rst     <= (state_nxt == S_IDLE) || (state_nxt == S_RESET) ||
                           (state_nxt == S_FAIL);
            sys_rst_out <= (state_nxt != S_RUN);
            ready       <= (state_nxt == S_RUN);
            fail        <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl with short parameters (4/20/8/2). The stimulus
// follows a fixed cycle timeline and queues the expected outputs for the
// cycles where the FSM should change state; the monitor compares them.
module tb_pll_lock_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET     = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_out;
    logic       ready;
    logic       fail;
    logic       lol_sticky;
    logic [2:0] retry_cnt;
    logic [2:0] state;

    pll_lock_ctrl #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .MAX_RETRIES     (2)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .enable     (enable),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_out(sys_rst_out),
        .ready      (ready),
        .fail       (fail),
        .lol_sticky (lol_sticky),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       fl;
        logic       lol;
        logic [2:0] rc;
        bit         rc_chk;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_bad = 0;
    logic [2:0] prev_state = 3'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] s, input logic pr,
                        input logic sr, input logic rd, input logic fl,
                        input logic lo, input logic [2:0] rc, input bit rcc);
        exp_t e;
        e.cyc = c; e.st = s; e.prst = pr; e.srst = sr; e.rdy = rd;
        e.fl = fl; e.lol = lo; e.rc = rc; e.rc_chk = rcc;
        exp_q.push_back(e);
    endtask

    // Return at the falling edge where the cycle counter equals n.
    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every state change must be an expected one, and every queued
    // expectation is compared against all outputs at its cycle.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_total++;
                n_bad++;
                $display("FAIL missed_check cyc=%0d got state=%0d want state=%0d at cyc %0d",
                         cyc, state, exp_q[0].st, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (state !== prev_state) begin
                n_total++;
                if (!(exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
                    n_bad++;
                    $display("FAIL unexpected_transition cyc=%0d got state=%0d (from %0d) want no change",
                             cyc, state, prev_state);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_total++;
                if (state !== e.st || pll_rst !== e.prst || sys_rst_out !== e.srst ||
                    ready !== e.rdy || fail !== e.fl || lol_sticky !== e.lol ||
                    (e.rc_chk && retry_cnt !== e.rc)) begin
                    n_bad++;
                    $display("FAIL chk_cyc%0d got st=%0d prst=%0b srst=%0b rdy=%0b fail=%0b lol=%0b rc=%0d want st=%0d prst=%0b srst=%0b rdy=%0b fail=%0b lol=%0b rc=%0d(chk=%0b)",
                             cyc, state, pll_rst, sys_rst_out, ready, fail, lol_sticky, retry_cnt,
                             e.st, e.prst, e.srst, e.rdy, e.fl, e.lol, e.rc, e.rc_chk);
                end
            end
        end
        prev_state <= state;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d got no end of test want end by cycle 160", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        pll_locked = 1'b0;
        push(2, S_IDLE, 1, 1, 0, 0, 0, 3'd0, 1);

        // Clean bring-up: lock appears at WAIT_LOCK entry (cycle 7).
        at_cyc(2);
        push(3,  S_RESET,     1, 1, 0, 0, 0, 3'd0, 1);
        push(7,  S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd0, 1);
        push(10, S_STABLE,    0, 1, 0, 0, 0, 3'd0, 1);
        push(18, S_RUN,       0, 0, 1, 0, 0, 3'd0, 1);
        rst    = 1'b0;
        enable = 1'b1;
        at_cyc(7);
        pll_locked = 1'b1;

        // Loss of lock in RUN: one-cycle drop, then relock.
        at_cyc(20);
        push(23, S_RESET,     1, 1, 0, 0, 1, 3'd0, 1);
        push(27, S_WAIT_LOCK, 0, 1, 0, 0, 1, 3'd0, 1);
        push(28, S_STABLE,    0, 1, 0, 0, 1, 3'd0, 1);
        push(36, S_RUN,       0, 0, 1, 0, 1, 3'd0, 1);
        pll_locked = 1'b0;
        at_cyc(21);
        pll_locked = 1'b1;

        // Reset for one cycle while in RUN.
        at_cyc(38);
        push(39, S_IDLE, 1, 1, 0, 0, 0, 3'd0, 1);
        rst = 1'b1;
        at_cyc(39);
        rst        = 1'b0;
        enable     = 1'b0;
        pll_locked = 1'b0;

        // Timeout with lock held low: two retries, then FAIL.
        at_cyc(41);
        push(42,  S_RESET,     1, 1, 0, 0, 0, 3'd0, 1);
        push(46,  S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd0, 1);
        push(66,  S_RESET,     1, 1, 0, 0, 0, 3'd1, 1);
        push(70,  S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd1, 1);
        push(90,  S_RESET,     1, 1, 0, 0, 0, 3'd2, 1);
        push(94,  S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd2, 1);
        push(114, S_FAIL,      1, 1, 0, 1, 0, 3'd2, 1);
        enable = 1'b1;

        // Abort from FAIL.
        at_cyc(116);
        push(117, S_IDLE, 1, 1, 0, 0, 0, 3'd0, 0);
        enable = 1'b0;

        // Chatter: lock toggles every 5 cycles from WAIT_LOCK entry (123);
        // timeout still fires 20 cycles later. Then abort from STABLE.
        at_cyc(118);
        push(119, S_RESET,     1, 1, 0, 0, 0, 3'd0, 1);
        push(123, S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd0, 1);
        push(126, S_STABLE,    0, 1, 0, 0, 0, 3'd0, 1);
        push(131, S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd0, 1);
        push(136, S_STABLE,    0, 1, 0, 0, 0, 3'd0, 1);
        push(141, S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd0, 1);
        push(143, S_RESET,     1, 1, 0, 0, 0, 3'd1, 1);
        push(147, S_WAIT_LOCK, 0, 1, 0, 0, 0, 3'd1, 1);
        push(148, S_STABLE,    0, 1, 0, 0, 0, 3'd1, 1);
        push(151, S_IDLE,      1, 1, 0, 0, 0, 3'd0, 0);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            at_cyc(123 + 5 * k);
            pll_locked = (k % 2 == 0);
        end
        at_cyc(150);
        enable = 1'b0;

        at_cyc(156);
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
